// File: rtl/fir_transposed_param.sv
// ----------------------------------------------------------------------------
// fir_transposed_param
//   Parametrised transposed-form FIR filter with a runtime-loadable,
//   double-buffered coefficient bank, round-half-up output scaling and a
//   cascade input/output for chaining filter sections.
//
// Optional feature macro: FIR_SAT_EN
//   defined   : scaled output is clipped to the DOUT_W signed range and any
//               clip sets the sticky oSat flag (cleared by reset or iClear).
//   undefined : scaled output wraps to its low DOUT_W bits; oSat is tied 0.
//
// Ports:
//   iClk_12M     in   1        system clock
//   iRst         in   1        asynchronous active-high reset
//   iEnSample    in   1        one-cycle sample strobe qualifying iFirIn
//   iFirIn       in   DIN_W    signed input sample
//   iCasc        in   ACC_W    signed cascade partial sum (far tap), tie 0 if unused
//   iClear       in   1        synchronous flush of the partial-sum chain
//   iCoefWe      in   1        shadow-bank coefficient write enable
//   iCoefAddr    in   AW       shadow coefficient index
//   iCoefData    in   COEF_W   signed coefficient value
//   iCoefCommit  in   1        request shadow-to-active swap
//   oCoefPending out  1        swap requested, not yet applied (FSM state)
//   oCasc        out  ACC_W    unscaled partial sum of tap 0, for cascading
//   oFirOut      out  DOUT_W   scaled output sample
//   oValid       out  1        one-cycle strobe qualifying oFirOut
//   oSat         out  1        sticky saturation flag
//
// Strobe semantics: there is no back-pressure. iEnSample is a one-cycle
// strobe; the sample it qualifies reaches oFirOut exactly two clocks later
// with oValid high for one cycle. Consecutive strobes give consecutive
// oValid cycles.
// ----------------------------------------------------------------------------
module fir_transposed_param #(
    parameter int NTAP      = 16,
    parameter int DIN_W     = 16,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 40,
    parameter int DOUT_W    = 16,
    parameter int OUT_SHIFT = 15,
    localparam int AW       = (NTAP > 1) ? $clog2(NTAP) : 1
) (
    input  logic                     iClk_12M,
    input  logic                     iRst,
    input  logic                     iEnSample,
    input  logic signed [DIN_W-1:0]  iFirIn,
    input  logic signed [ACC_W-1:0]  iCasc,
    input  logic                     iClear,
    input  logic                     iCoefWe,
    input  logic [AW-1:0]            iCoefAddr,
    input  logic signed [COEF_W-1:0] iCoefData,
    input  logic                     iCoefCommit,
    output logic                     oCoefPending,
    output logic signed [ACC_W-1:0]  oCasc,
    output logic signed [DOUT_W-1:0] oFirOut,
    output logic                     oValid,
    output logic                     oSat
);

    localparam int PW = DIN_W + COEF_W;

    // Rounding constant 2^(OUT_SHIFT-1); the shift-up-then-down form gives 0
    // when OUT_SHIFT is 0 without a negative shift amount.
    localparam logic [ACC_W:0]        ONE_EXT = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] ROUND   = (ONE_EXT << OUT_SHIFT) >> 1;

    // ------------------------------------------------------------------
    // Coefficient banks and swap FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } coef_state_t;

    coef_state_t state, state_next;
    logic        swap;

    logic signed [COEF_W-1:0] coef_act [NTAP];
    logic signed [COEF_W-1:0] coef_shd [NTAP];
    logic signed [COEF_W-1:0] shd_next [NTAP];

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A commit waits for the next sample strobe so a sample never sees a
    // mix of old and new coefficients. The strobe that applies the swap
    // still filters with the old bank (products are formed before the edge).
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        case (state)
            IDLE: if (iCoefCommit) state_next = PEND;
            PEND: if (iEnSample) begin
                swap       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign oCoefPending = (state == PEND);

    // Shadow contents including this cycle's write, so a write in the swap
    // cycle lands in the active bank as well.
    always_comb begin
        shd_next = coef_shd;
        if (iCoefWe && (32'(iCoefAddr) < NTAP)) begin
            shd_next[iCoefAddr] = iCoefData;
        end
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < NTAP; k++) begin
                coef_act[k] <= '0;
                coef_shd[k] <= '0;
            end
        end else begin
            coef_shd <= shd_next;
            if (swap) begin
                coef_act <= shd_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Products and transposed partial-sum chain
    // ------------------------------------------------------------------
    logic signed [PW-1:0]    mult [NTAP];
    logic signed [ACC_W-1:0] prod [NTAP];
    logic signed [ACC_W-1:0] shift_q [NTAP];

    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            mult[k] = PW'(iFirIn) * PW'(coef_act[k]);
            prod[k] = ACC_W'(mult[k]);
        end
    end

    // Chain overflow wraps silently at ACC_W bits.
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < NTAP; k++) shift_q[k] <= '0;
        end else if (iClear) begin
            for (int k = 0; k < NTAP; k++) shift_q[k] <= '0;
        end else if (iEnSample) begin
            for (int k = 0; k < NTAP - 1; k++) begin
                shift_q[k] <= shift_q[k+1] + prod[k];
            end
            shift_q[NTAP-1] <= iCasc + prod[NTAP-1];
        end
    end

    assign oCasc = shift_q[0];

    // ------------------------------------------------------------------
    // Output scaling
    // ------------------------------------------------------------------
    // One guard bit keeps the rounding add from overflowing.
    logic signed [ACC_W:0]    rounded;
    logic signed [ACC_W:0]    scaled;
    logic signed [DOUT_W-1:0] out_next;

    assign rounded = {shift_q[0][ACC_W-1], shift_q[0]} + ROUND;
    assign scaled  = rounded >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W:0] OUT_MAX =
        {{(ACC_W - DOUT_W + 2){1'b0}}, {(DOUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    logic clip;

    always_comb begin
        out_next = DOUT_W'(scaled);
        clip     = 1'b0;
        if (scaled > OUT_MAX) begin
            out_next = DOUT_W'(OUT_MAX);
            clip     = 1'b1;
        end else if (scaled < OUT_MIN) begin
            out_next = DOUT_W'(OUT_MIN);
            clip     = 1'b1;
        end
    end
`else
    assign out_next = DOUT_W'(scaled);
    assign oSat     = 1'b0;
`endif

    // valid_pend marks that the chain was loaded with a real sample at the
    // previous edge; a strobe dropped by iClear never sets it.
    logic valid_pend;

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            valid_pend <= 1'b0;
            oValid     <= 1'b0;
            oFirOut    <= '0;
        end else begin
            valid_pend <= iEnSample & ~iClear;
            oValid     <= valid_pend;
            if (valid_pend) begin
                oFirOut <= out_next;
            end
        end
    end

`ifdef FIR_SAT_EN
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            oSat <= 1'b0;
        end else if (iClear) begin
            oSat <= 1'b0;
        end else if (valid_pend && clip) begin
            oSat <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/fir_transposed_param.md
Name: fir_transposed_param

Overview:
- Parametrised transposed-form FIR filter, the successor to the fixed 10-tap, 16-bit transposed MAC block.
- Configurable tap count, data width, coefficient width and accumulator width.
- Coefficients are runtime-loadable through a double-buffered bank that swaps only on a sample boundary.
- Output has round-half-up scaling and a one-cycle valid strobe; a cascade input allows chaining filter sections.

Parameters:
- NTAP, 16, number of taps (2..64).
- DIN_W, 16, signed input sample width.
- COEF_W, 16, signed coefficient width.
- ACC_W, 40, signed partial-sum register width; must be >= DIN_W+COEF_W+clog2(NTAP).
- DOUT_W, 16, signed output width.
- OUT_SHIFT, 15, arithmetic right shift applied before output; 0 allowed.

Ports:
- iClk_12M  in  1  system clock
- iRst  in  1  asynchronous active-high reset
- iEnSample  in  1  one-cycle sample strobe; iFirIn is valid in this cycle
- iFirIn  in  DIN_W  signed input sample
- iCasc  in  ACC_W  signed cascade partial sum, added at the far tap; tie 0 if unused
- iClear  in  1  synchronous flush of the partial-sum chain
- iCoefWe  in  1  shadow-bank coefficient write enable
- iCoefAddr  in  clog2(NTAP)  shadow coefficient index
- iCoefData  in  COEF_W  signed coefficient value
- iCoefCommit  in  1  request shadow-to-active swap
- oCoefPending  out  1  swap requested, not yet applied
- oCasc  out  ACC_W  unscaled partial sum rShift[0], for cascading
- oFirOut  out  DOUT_W  scaled output sample
- oValid  out  1  one-cycle strobe qualifying oFirOut
- oSat  out  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset (async, iRst=1):
  - rShift[0..NTAP-1], active bank, shadow bank, oFirOut, oCasc = 0.
  - oValid, oCoefPending, oSat = 0.
- Products: p[k] = iFirIn*cA[k], full precision, then sign-extended to ACC_W. cA is the active bank.
- On iEnSample=1, at the clock edge:
  - rShift[NTAP-1] <= iCasc + p[NTAP-1].
  - rShift[k] <= rShift[k+1] + p[k] for k = NTAP-2..0.
- Result: y[n] = sum over k of cA[k]*x[n-k] (+ cascade contribution), held in rShift[0] after the edge of sample n.
- Output stage, the edge after a sample edge:
  - oFirOut <= sat_or_wrap((rShift[0] + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT). No rounding term when OUT_SHIFT=0.
  - oValid = 1 for exactly that one cycle.
  - Latency: iEnSample to oValid = 2 clocks.
- oCasc = rShift[0], registered.
- iEnSample=0: chain holds its value; no oValid.
- Overflow in the chain (ACC_W too small) wraps silently.
- Back-to-back iEnSample on consecutive cycles is legal; oValid is then high on consecutive cycles.
- iClear=1: all rShift <= 0 at the edge, with priority over iEnSample. The sample in that cycle is dropped and no oValid results from it. oValid for an earlier sample still fires.
- Coefficient FSM, states IDLE and PEND:
  - iCoefWe writes the shadow bank in any state; the active bank is unaffected.
  - IDLE + iCoefCommit -> PEND, oCoefPending=1.
  - PEND + iEnSample: that sample uses the old active bank; active <= shadow at the same edge; -> IDLE.
  - Commit in the same cycle as iEnSample while in IDLE: enter PEND; the swap occurs at the next strobe.
  - Commit while in PEND: no effect.
  - Write and swap in the same cycle: the new write is included in the swap.
  - iClear does not affect the coefficient FSM.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined:
  - Scaled value clipped to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1].
  - Any clip sets oSat=1.
  - oSat is sticky until reset or iClear.
- Undefined:
  - Scaled value truncated to the low DOUT_W bits (two's-complement wrap).
  - oSat tied to 0.

Test Plan:
- Impulse: NTAP=16, OUT_SHIFT=0, coefficients 1..16 committed before first strobe; x = 1, then 0 x15 -> oFirOut = 1,2,...,16 on successive oValid; each oValid 2 clocks after its strobe.
- Swap timing: active all 1, shadow all 2; commit, then strobe with x=1 -> oCoefPending drops at that strobe; that output = 1; a following strobe with x=1 -> 1+2 = 3.
- Rounding: OUT_SHIFT=15, single tap 16384, x=1 -> (16384+16384)>>>15 = 1; x=-1 -> (-16384+16384)>>>15 = 0.
- Saturation (FIR_SAT_EN): all taps 32767, OUT_SHIFT=0, x=32767 -> oFirOut = 32767, oSat = 1; iClear -> oSat = 0. Without the macro, same stimulus -> wrapped low 16 bits, oSat = 0.
- Flush/reset: iClear together with a strobe mid-stream -> no oValid for that sample; next impulse response starts clean. Assert iRst between strobe and oValid -> oValid never rises; all outputs 0 asynchronously.
- Cascade: iCasc = 1000, all coefficients 0, OUT_SHIFT=0, strobe -> after NTAP strobes oCasc = 1000 and oFirOut = sat(1000).
